// File: rtl/weight_fetch_ctrl.sv
// Purpose : shares one combinational weight ROM between two requesters and
//           streams each accepted burst through a one-word output register.
// Latency : gnt/rom_en one cycle after the request is sampled; first w_valid one cycle later.
// Backpres: w_ready=0 with a word held stalls ROM reads in the same cycle; nothing dropped.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req0/1, base0/1,    burst requests (sampled in IDLE only); len==0 is ignored
//   len0/1
//   gnt                 one-hot pulse in the first READ cycle of an accepted burst
//   rom_addr, rom_en,   ROM read port; rom_data is valid in the same cycle as rom_en
//   rom_data
//   w_data, w_valid,    valid/ready word stream to the burst owner, w_last on final word
//   w_ready, w_last
//   w_owner, busy       owner of the current burst, burst in progress
//
// Build option: define WFC_ROUND_ROBIN_EN for round-robin arbitration on a tie;
// otherwise requester 0 has fixed priority and the pointer logic is absent.

module weight_fetch_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] base0,
    input  logic [ADDR_W-1:0] base1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    output logic [1:0]        gnt,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last,
    output logic              w_owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              first_cyc;   // marks the first READ cycle, drives the gnt pulse

    logic elig0, elig1, any_elig, accept, win;
    logic out_fire, last_read;

    assign elig0    = req0 && (len0 != '0);
    assign elig1    = req1 && (len1 != '0);
    assign any_elig = elig0 || elig1;
    assign accept   = (state == IDLE) && any_elig;
    assign out_fire = w_valid && w_ready;
    assign last_read = (remaining == LEN_W'(1));

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef WFC_ROUND_ROBIN_EN
    // Index of the requester granted most recently; reset value of 1 means
    // requester 0 wins the first tie after reset.
    logic last_gnt;

    always_comb begin
        win = 1'b0;
        if (elig0 && elig1) begin
            win = ~last_gnt;
        end else begin
            win = elig1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (accept) begin
            last_gnt <= win;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is not eligible.
    always_comb begin
        win = elig1 && !elig0;
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and ROM-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        rom_en    = 1'b0;
        gnt       = 2'b00;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                // A read may proceed when the output register is empty or is
                // being emptied on this same edge.
                rom_en = !w_valid || w_ready;
                if (first_cyc) begin
                    gnt = w_owner ? 2'b10 : 2'b01;
                end
                if (rom_en && last_read) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rom_addr = cur_addr;
    assign busy     = (state != IDLE);

    // ------------------------------------------------------------------
    // Burst bookkeeping and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            w_owner   <= 1'b0;
            first_cyc <= 1'b0;
            w_data    <= '0;
            w_valid   <= 1'b0;
            w_last    <= 1'b0;
        end else begin
            first_cyc <= 1'b0;

            if (accept) begin
                cur_addr  <= win ? base1 : base0;
                remaining <= win ? len1 : len0;
                w_owner   <= win;
                first_cyc <= 1'b1;
            end

            if (rom_en) begin
                // Refill on the same edge a held word leaves keeps one word/cycle.
                w_data    <= rom_data;
                w_valid   <= 1'b1;
                w_last    <= last_read;
                cur_addr  <= cur_addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end else if (out_fire) begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Purpose : directed self-checking bench for weight_fetch_ctrl with a ROM model.
// Latency : inputs driven and outputs sampled 1-2 time units after each rising edge.
// Backpres: exercises w_ready held high and a 1,0,0,1 stall pattern.

module tb_weight_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] base0, base1;
    logic [4:0] len0, len1;
    logic [1:0] gnt;
    logic [7:0] rom_addr;
    logic       rom_en;
    logic [7:0] rom_data;
    logic [7:0] w_data;
    logic       w_valid;
    logic       w_ready;
    logic       w_last;
    logic       w_owner;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // ROM contents: nibble swap xor A5, so every address gives a distinct word.
    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'hA5;
    endfunction

    assign rom_data = rom_en ? rom_f(rom_addr) : 8'h00;

    weight_fetch_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .base0    (base0),
        .base1    (base1),
        .len0     (len0),
        .len1     (len1),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .rom_data (rom_data),
        .w_data   (w_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_last   (w_last),
        .w_owner  (w_owner),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs_zero(input string tag);
        chk({tag, "_gnt"},      32'(gnt),      32'd0);
        chk({tag, "_rom_en"},   32'(rom_en),   32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_w_data"},   32'(w_data),   32'd0);
        chk({tag, "_w_valid"},  32'(w_valid),  32'd0);
        chk({tag, "_w_last"},   32'(w_last),   32'd0);
        chk({tag, "_w_owner"},  32'(w_owner),  32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    // Leaves the bench at a sample point (1 unit after a rising edge).
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outs_zero("rst");
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (gnt != 2'b00) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_gnt_seen"}, 32'(seen), 32'd1);
    endtask

    // Starts at the sample point of the first READ cycle. mode 0: w_ready held 1;
    // mode 1: w_ready follows 1,0,0,1 per cycle. Returns early after 'stop' words.
    task automatic run_burst(input string tag, input int owner, input logic [7:0] base,
                             input int len, input int mode, input int stop);
        int         n = 0;
        int         k = 0;
        bit         pstall = 1'b0;
        logic [7:0] pd = 8'h00;
        logic       pl = 1'b0;
        logic [7:0] a;
        bit         done = 1'b0;
        while (!done && k < 200) begin
            w_ready = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
            #1;
            if (k == 0) begin
                chk({tag, "_gnt"},      32'(gnt),      (owner != 0) ? 32'd2 : 32'd1);
                chk({tag, "_rom_addr0"}, 32'(rom_addr), 32'(base));
                chk({tag, "_rom_en0"},  32'(rom_en),   32'd1);
                chk({tag, "_busy"},     32'(busy),     32'd1);
            end
            if (k == 1) chk({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
            if (pstall) begin
                chk({tag, "_hold_data"}, 32'(w_data), 32'(pd));
                chk({tag, "_hold_last"}, 32'(w_last), 32'(pl));
            end
            if (w_valid && !w_ready) chk({tag, "_stall_rom_en"}, 32'(rom_en), 32'd0);
            pstall = w_valid && !w_ready;
            pd = w_data;
            pl = w_last;
            if (w_valid && w_ready) begin
                a = base + 8'(n);
                chk({tag, "_data"},  32'(w_data),  32'(rom_f(a)));
                chk({tag, "_last"},  32'(w_last),  32'(n == len - 1));
                chk({tag, "_owner"}, 32'(w_owner), 32'(owner));
                if (mode == 0) chk({tag, "_cycle"}, 32'(k), 32'(n + 1));
                n++;
                if (n == stop) begin
                    return;
                end
                if (n == len) done = 1'b1;
            end
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_words"}, 32'(n), 32'(len));
        if (done) begin
            chk({tag, "_idle_busy"},  32'(busy),    32'd0);
            chk({tag, "_idle_valid"}, 32'(w_valid), 32'd0);
        end
    endtask

    int exp_own [3];

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        base0 = 8'h00; base1 = 8'h00;
        len0 = 5'd0; len1 = 5'd0;
        w_ready = 1'b1;

        do_reset();

        // 6-word burst from requester 0, w_ready held high
        req0 = 1'b1; base0 = 8'h00; len0 = 5'd6;
        @(posedge clk); #1;
        wait_gnt("b6");
        req0 = 1'b0;
        run_burst("b6", 0, 8'h00, 6, 0, 99);

        // same burst with a stalling consumer
        req0 = 1'b1; base0 = 8'h00; len0 = 5'd6;
        @(posedge clk); #1;
        wait_gnt("stall");
        req0 = 1'b0;
        run_burst("stall", 0, 8'h00, 6, 1, 99);
        w_ready = 1'b1;

        // tie arbitration from a fresh pointer
        do_reset();
`ifdef WFC_ROUND_ROBIN_EN
        exp_own = '{0, 1, 0};
`else
        exp_own = '{0, 0, 0};
`endif
        req0 = 1'b1; base0 = 8'h10; len0 = 5'd2;
        req1 = 1'b1; base1 = 8'h20; len1 = 5'd2;
        @(posedge clk); #1;
        for (int b = 0; b < 3; b++) begin
            wait_gnt("arb");
            if (b == 2) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            run_burst("arb", exp_own[b], (exp_own[b] != 0) ? 8'h20 : 8'h10, 2, 0, 99);
        end

        // address wrap on requester 1
        req1 = 1'b1; base1 = 8'hFF; len1 = 5'd2;
        @(posedge clk); #1;
        wait_gnt("wrap");
        req1 = 1'b0;
        run_burst("wrap", 1, 8'hFF, 2, 0, 99);

        // zero-length request is ignored
        req0 = 1'b1; base0 = 8'h30; len0 = 5'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("len0_gnt",  32'(gnt),  32'd0);
            chk("len0_busy", 32'(busy), 32'd0);
        end
        req0 = 1'b0;

        // reset in the middle of a burst after three words
        req0 = 1'b1; base0 = 8'h40; len0 = 5'd6;
        @(posedge clk); #1;
        wait_gnt("mid");
        req0 = 1'b0;
        run_burst("mid", 0, 8'h40, 6, 0, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check_outs_zero("midrst");
        rst = 1'b0;

        // fresh burst after the abandoned one starts at its own base
        req0 = 1'b1; base0 = 8'h80; len0 = 5'd2;
        @(posedge clk); #1;
        wait_gnt("fresh");
        req0 = 1'b0;
        run_burst("fresh", 0, 8'h80, 2, 0, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Controller that shares the single combinational weight ROM between two requesters, such as the conv engine and the FC engine. It accepts one burst request at a time, covering a base address and a length. It sequences `rom_addr`/`rom_en` to read that burst and streams the words to the granted requester over a valid/ready interface with a one-word output register. It sits between the ROM read port and the compute engines' weight-load logic.

## Interface
- `ADDR_W`, 8, ROM address width; addresses wrap modulo 2^ADDR_W
- `DATA_W`, 8, weight word width
- `LEN_W`, 5, burst length field width; max burst 2^LEN_W−1 words
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req0`, `req1`  in  1  burst request from requester 0/1; held until its grant
- `base0`, `base1`  in  ADDR_W  first ROM address of the burst
- `len0`, `len1`  in  LEN_W  words in the burst; 0 = request ignored
- `gnt`  out  2  one-hot, one-cycle pulse when a request is accepted
- `rom_addr`  out  ADDR_W  ROM address
- `rom_en`  out  1  ROM read enable
- `rom_data`  in  DATA_W  ROM data, valid in the same cycle as `rom_en`/`rom_addr`; don't-care (z) when `rom_en`=0
- `w_data`  out  DATA_W  weight word to requester
- `w_valid`  out  1  `w_data` valid
- `w_ready`  in  1  requester accepts word
- `w_last`  out  1  qualifies the final word of the burst
- `w_owner`  out  1  index of the requester owning the current burst
- `busy`  out  1  burst in progress (state ≠ IDLE)

## Operation
- States: IDLE, READ, DRAIN.
- IDLE:
  - A requester is eligible when `reqN`=1 and `lenN`≠0.
  - If any requester is eligible, arbitrate. Latch `baseN`→`cur_addr`, `lenN`→`remaining`, and the winner→`w_owner`. Go to READ.
- READ:
  - `gnt[w_owner]`=1 in the first READ cycle only.
  - `rom_en` = (state==READ) && (!`w_valid` || `w_ready`). `rom_addr`=`cur_addr` (held when `rom_en`=0).
  - On each edge with `rom_en`=1:
    - Capture `rom_data` into `w_data`; set `w_valid`=1.
    - `cur_addr`+1 (mod 2^ADDR_W); `remaining`−1.
    - `w_last` ← (`remaining`==1).
  - After the read where `remaining`==1, go to DRAIN.
- DRAIN: hold until `w_valid`&&`w_ready` for the last word, then go to IDLE.
- Output register:
  - `w_valid` clears on `w_valid`&&`w_ready` unless a new read is captured on the same edge.
  - `w_data`/`w_last` are stable while `w_valid`=1 and `w_ready`=0.
- Requests are sampled only in IDLE. `base`/`len` changes after acceptance have no effect.
- Simultaneous eligible requests are resolved by the arbitration policy (see Configuration).
- Reset (any state, including mid-burst):
  - state=IDLE.
  - All outputs 0: `gnt`=0, `rom_en`=0, `rom_addr`=0, `w_data`=0, `w_valid`=0, `w_last`=0, `w_owner`=0, `busy`=0.
  - The in-flight burst is abandoned with no `w_last`.
  - Arbitration pointer "last granted" = 1.

## Timing
- Request eligible at edge E (IDLE) → READ from E+1.
  - `gnt` and `rom_en` high, `rom_addr`=base, during cycle E+1.
  - First `w_valid` during cycle E+2.
- With `w_ready` held 1, an L-word burst gives:
  - `w_valid` for cycles E+2..E+L+1.
  - `w_last` in cycle E+L+1.
  - IDLE (`busy`=0) in cycle E+L+2, when the next request can be sampled.
- Throughput is one word/cycle. `w_ready`=0 stalls ROM reads in the same cycle; no word is dropped or duplicated.
- Address wrap: base=0xFE, len=3 reads 0xFE, 0xFF, 0x00.

## Configuration
- `WFC_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration; on a tie the requester not granted last wins.
  - The pointer updates on each grant.
- Not defined:
  - Fixed priority; requester 0 always wins a tie.
  - The pointer logic is absent.

## Test plan
- Reset then req0, base0=0x00, len0=6, `w_ready`=1 → gnt=01 one cycle; `w_data`=ROM[0..5] on consecutive cycles; `w_last` on 6th word; `busy` low 1 cycle later.
- Same burst with `w_ready` toggling 1,0,0,1,… → `rom_en` low during stalls; all 6 words delivered in order exactly once; `w_data` stable while stalled.
- req0 and req1 both held with len=2 for three bursts:
  - Round-robin build: grant order 0,1,0.
  - Fixed-priority build: 0,0,0 while req0 stays high.
- req1, base1=0xFF, len1=2 → reads 0xFF then 0x00; `w_owner`=1 throughout.
- req0 with len0=0 → no gnt, `busy` stays 0; `rst` asserted mid-burst after 3 words → next cycle all outputs 0, no `w_last`; a fresh req0 afterwards starts at its base.
